slc3_isdu: RTL and testbench

Instruction sequencing and decode unit for the SLC-3 CPU. A Moore state machine that drives every load, gate, mux-select and memory strobe of the SLC-3 datapath. It fetches, decodes and executes ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR and PAUSE. Memory accesses are held for a programmable number of wait cycles. It sits between the top-level CPU wrapper and the datapath.

---
 rtl/slc3_pkg.sv | 72 +++++++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/slc3_isdu.sv | 237 +++++++++++++++++++++++
 tb/tb_slc3_isdu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: ISDU state encoding, opcodes, and the mux/ALUK
// select encodings that the datapath decodes.
// Optional feature macro: SLC3_PAUSE_EN adds the two Pause states.
package slc3_pkg;

    typedef enum logic [4:0] {
        ST_HALTED,
        ST_S18,
        ST_S33,
        ST_S35,
        ST_S32,
        ST_S1,
        ST_S5,
        ST_S9,
        ST_S0,
        ST_S22,
        ST_S12,
        ST_S4,
        ST_S21,
        ST_S20,
        ST_S6,
        ST_S7,
        ST_S25,
        ST_S27,
        ST_S23,
        ST_S16
`ifdef SLC3_PAUSE_EN
        ,
        ST_PAUSE1,
        ST_PAUSE2
`endif
    } state_e;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic       SR2MUX_IMM   = 1'b0;
    localparam logic       SR2MUX_REG   = 1'b1;
    localparam logic       ADDR1_PC     = 1'b0;
    localparam logic       ADDR1_SR1    = 1'b1;
    localparam logic       DRMUX_IR     = 1'b0;
    localparam logic       DRMUX_R7     = 1'b1;
    localparam logic       SR1MUX_IR11  = 1'b0;
    localparam logic       SR1MUX_IR8   = 1'b1;
    localparam logic       MARMUX_ADDER = 1'b0;

    localparam logic [1:0] PCMUX_PC1    = 2'b00;
    localparam logic [1:0] PCMUX_BUS    = 2'b01;
    localparam logic [1:0] PCMUX_ADDER  = 2'b10;

    localparam logic [1:0] ADDR2_ZERO   = 2'b00;
    localparam logic [1:0] ADDR2_OFF6   = 2'b01;
    localparam logic [1:0] ADDR2_OFF9   = 2'b10;
    localparam logic [1:0] ADDR2_OFF11  = 2'b11;

    localparam logic [1:0] ALUK_ADD     = 2'b00;
    localparam logic [1:0] ALUK_AND     = 2'b01;
    localparam logic [1:0] ALUK_NOT     = 2'b10;
    localparam logic [1:0] ALUK_PASS    = 2'b11;

    function automatic logic is_mem_state(input state_e s);
        return (s == ST_S33) || (s == ST_S25) || (s == ST_S16);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory access wait timer: loadable down-counter with a terminal-count flag.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : reload with MEM_WAIT-1 (held while outside a memory state)
//   en         : count down while inside a memory state
//   last       : current cycle is the final cycle of the access
module mem_wait_timer #(
    parameter int MEM_WAIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam logic [3:0] LOAD_VAL = 4'(MEM_WAIT - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD_VAL;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign last = (cnt == 4'd0);

endmodule

// File: rtl/slc3_isdu.sv
// SLC-3 instruction sequencing and decode unit (Moore FSM).
// Drives all loads, bus gates, mux selects and memory strobes of the datapath.
// Optional feature macro: SLC3_PAUSE_EN (PAUSE opcode 1101 with LED/Continue
// handshake); when undefined, 1101 is illegal, ld_led is 0, cont is ignored.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   run, cont             : start from Halted, resume from Pause
//   opcode, ir_5, ir_11   : IR[15:12], IR[5], IR[11]
//   ben                   : branch enable
//   ld_*                  : register load strobes
//   gate_*                : bus drivers (one-hot or none)
//   sr2mux..aluk          : datapath selects
//   mem_oe, mem_we        : active-high memory strobes, held MEM_WAIT cycles
//
// state    | meaning
// HALTED   | idle, wait for run
// S18      | MAR<-PC, PC<-PC+1
// S33      | fetch read, MDR<-M on last cycle
// S35      | IR<-MDR
// S32      | BEN<-cond, dispatch on opcode
// S1/S5/S9 | ADD / AND / NOT
// S0, S22  | BR test, PC<-PC+off9
// S12      | JMP, PC<-SR1
// S4       | JSR, R7<-PC
// S21, S20 | PC<-PC+off11 / PC<-SR1
// S6, S7   | MAR<-SR1+off6 (LDR / STR)
// S25, S27 | LDR read, DR<-MDR
// S23, S16 | MDR<-SR, STR write
// PAUSE1/2 | LED shown, wait cont high / low
module slc3_isdu
    import slc3_pkg::*;
#(
    parameter int MEM_WAIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       cont,
    input  logic [3:0] opcode,
    input  logic       ir_5,
    input  logic       ir_11,
    input  logic       ben,
    output logic       ld_mar,
    output logic       ld_mdr,
    output logic       ld_ir,
    output logic       ld_ben,
    output logic       ld_cc,
    output logic       ld_reg,
    output logic       ld_pc,
    output logic       ld_led,
    output logic       gate_pc,
    output logic       gate_mdr,
    output logic       gate_alu,
    output logic       gate_marmux,
    output logic       sr2mux,
    output logic       addr1mux,
    output logic       marmux,
    output logic       drmux,
    output logic       sr1mux,
    output logic       mio_en,
    output logic [1:0] pcmux,
    output logic [1:0] addr2mux,
    output logic [1:0] aluk,
    output logic       mem_oe,
    output logic       mem_we
);

    state_e state;
    logic   imm_sel;
    logic   in_mem;
    logic   last;

`ifndef SLC3_PAUSE_EN
    logic unused_cont;
    assign unused_cont = cont;
`endif

    assign in_mem = is_mem_state(state);

    mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (~in_mem),
        .en    (in_mem),
        .last  (last)
    );

    // IR[5] is captured at dispatch so that sr2mux is driven from a flop
    // rather than straight from the input pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_HALTED;
            imm_sel <= 1'b0;
        end else begin
            if (state == ST_S32) imm_sel <= ir_5;
            case (state)
                ST_HALTED: if (run) state <= ST_S18;
                ST_S18:    state <= ST_S33;
                ST_S33:    if (last) state <= ST_S35;
                ST_S35:    state <= ST_S32;
                ST_S32: begin
                    case (opcode)
                        OP_ADD:   state <= ST_S1;
                        OP_AND:   state <= ST_S5;
                        OP_NOT:   state <= ST_S9;
                        OP_BR:    state <= ST_S0;
                        OP_JMP:   state <= ST_S12;
                        OP_JSR:   state <= ST_S4;
                        OP_LDR:   state <= ST_S6;
                        OP_STR:   state <= ST_S7;
`ifdef SLC3_PAUSE_EN
                        OP_PAUSE: state <= ST_PAUSE1;
`endif
                        default:  state <= ST_S18;
                    endcase
                end
                ST_S0:     state <= ben ? ST_S22 : ST_S18;
                ST_S4:     state <= ir_11 ? ST_S21 : ST_S20;
                ST_S6:     state <= ST_S25;
                ST_S25:    if (last) state <= ST_S27;
                ST_S7:     state <= ST_S23;
                ST_S23:    state <= ST_S16;
                ST_S16:    if (last) state <= ST_S18;
`ifdef SLC3_PAUSE_EN
                ST_PAUSE1: if (cont) state <= ST_PAUSE2;
                ST_PAUSE2: if (!cont) state <= ST_S18;
`endif
                ST_S1, ST_S5, ST_S9, ST_S22, ST_S12,
                ST_S21, ST_S20, ST_S27: state <= ST_S18;
                default:   state <= ST_HALTED;
            endcase
        end
    end

    assign marmux = MARMUX_ADDER;

    always_comb begin
        ld_mar      = 1'b0;
        ld_mdr      = 1'b0;
        ld_ir       = 1'b0;
        ld_ben      = 1'b0;
        ld_cc       = 1'b0;
        ld_reg      = 1'b0;
        ld_pc       = 1'b0;
        ld_led      = 1'b0;
        gate_pc     = 1'b0;
        gate_mdr    = 1'b0;
        gate_alu    = 1'b0;
        gate_marmux = 1'b0;
        sr2mux      = 1'b0;
        addr1mux    = 1'b0;
        drmux       = 1'b0;
        sr1mux      = 1'b0;
        mio_en      = 1'b0;
        pcmux       = 2'b00;
        addr2mux    = 2'b00;
        aluk        = 2'b00;
        mem_oe      = 1'b0;
        mem_we      = 1'b0;
        case (state)
            ST_S18: begin
                gate_pc = 1'b1;
                ld_mar  = 1'b1;
                ld_pc   = 1'b1;
                pcmux   = PCMUX_PC1;
            end
            ST_S33, ST_S25: begin
                mio_en = 1'b1;
                mem_oe = 1'b1;
                ld_mdr = last;
            end
            ST_S35: begin
                gate_mdr = 1'b1;
                ld_ir    = 1'b1;
            end
            ST_S32: ld_ben = 1'b1;
            ST_S1, ST_S5, ST_S9: begin
                gate_alu = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
                sr1mux   = SR1MUX_IR8;
                sr2mux   = imm_sel ? SR2MUX_IMM : SR2MUX_REG;
                aluk     = (state == ST_S5) ? ALUK_AND :
                           (state == ST_S9) ? ALUK_NOT : ALUK_ADD;
            end
            ST_S22: begin
                addr1mux = ADDR1_PC;
                addr2mux = ADDR2_OFF9;
                pcmux    = PCMUX_ADDER;
                ld_pc    = 1'b1;
            end
            ST_S12, ST_S20: begin
                addr1mux = ADDR1_SR1;
                addr2mux = ADDR2_ZERO;
                sr1mux   = SR1MUX_IR8;
                pcmux    = PCMUX_ADDER;
                ld_pc    = 1'b1;
            end
            ST_S4: begin
                gate_pc = 1'b1;
                drmux   = DRMUX_R7;
                ld_reg  = 1'b1;
            end
            ST_S21: begin
                addr1mux = ADDR1_PC;
                addr2mux = ADDR2_OFF11;
                pcmux    = PCMUX_ADDER;
                ld_pc    = 1'b1;
            end
            ST_S6, ST_S7: begin
                addr1mux    = ADDR1_SR1;
                addr2mux    = ADDR2_OFF6;
                sr1mux      = SR1MUX_IR8;
                gate_marmux = 1'b1;
                ld_mar      = 1'b1;
            end
            ST_S27: begin
                gate_mdr = 1'b1;
                drmux    = DRMUX_IR;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
            end
            ST_S23: begin
                sr1mux   = SR1MUX_IR11;
                aluk     = ALUK_PASS;
                gate_alu = 1'b1;
                ld_mdr   = 1'b1;
            end
            ST_S16: mem_we = 1'b1;
`ifdef SLC3_PAUSE_EN
            ST_PAUSE1: ld_led = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slc3_isdu.sv
module tb_slc3_isdu;

    typedef logic [25:0] vec_t;
    typedef struct {
        string tag;
        vec_t  exp;
    } exp_t;

    // Observed vector layout (MSB first):
    // ld_mar ld_mdr ld_ir ld_ben ld_cc ld_reg ld_pc ld_led gate_pc gate_mdr
    // gate_alu gate_marmux sr2mux addr1mux marmux drmux sr1mux mio_en
    // pcmux[1:0] addr2mux[1:0] aluk[1:0] mem_oe mem_we
    localparam vec_t LD_MAR      = 26'h1 << 25;
    localparam vec_t LD_MDR      = 26'h1 << 24;
    localparam vec_t LD_IR       = 26'h1 << 23;
    localparam vec_t LD_BEN      = 26'h1 << 22;
    localparam vec_t LD_CC       = 26'h1 << 21;
    localparam vec_t LD_REG      = 26'h1 << 20;
    localparam vec_t LD_PC       = 26'h1 << 19;
    localparam vec_t LD_LED      = 26'h1 << 18;
    localparam vec_t GATE_PC     = 26'h1 << 17;
    localparam vec_t GATE_MDR    = 26'h1 << 16;
    localparam vec_t GATE_ALU    = 26'h1 << 15;
    localparam vec_t GATE_MARMUX = 26'h1 << 14;
    localparam vec_t SR2MUX      = 26'h1 << 13;
    localparam vec_t ADDR1MUX    = 26'h1 << 12;
    localparam vec_t DRMUX       = 26'h1 << 10;
    localparam vec_t SR1MUX      = 26'h1 << 9;
    localparam vec_t MIO_EN      = 26'h1 << 8;
    localparam vec_t PC_ADDER    = 26'h2 << 6;
    localparam vec_t A2_OFF6     = 26'h1 << 4;
    localparam vec_t A2_OFF9     = 26'h2 << 4;
    localparam vec_t A2_OFF11    = 26'h3 << 4;
    localparam vec_t K_AND       = 26'h1 << 2;
    localparam vec_t K_NOT       = 26'h2 << 2;
    localparam vec_t K_PASS      = 26'h3 << 2;
    localparam vec_t MEM_OE      = 26'h1 << 1;
    localparam vec_t MEM_WE      = 26'h1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst_n_v = 3'b000;
    logic              run = 1'b0, cont = 1'b0, ir_5 = 1'b0, ir_11 = 1'b0, ben = 1'b0;
    logic [3:0]        opcode = 4'b0000;
    logic [2:0][25:0]  obs;
    int                act = 0;
    int                n_checks = 0;
    int                n_errors = 0;
    exp_t              sb_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MW = (g == 0) ? 1 : ((g == 1) ? 3 : 15);
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic sr2mux, addr1mux, marmux, drmux, sr1mux, mio_en, mem_oe, mem_we;
        logic [1:0] pcmux, addr2mux, aluk;

        slc3_isdu #(.MEM_WAIT(MW)) u_dut (
            .clk(clk), .rst_n(rst_n_v[g]), .run(run), .cont(cont),
            .opcode(opcode), .ir_5(ir_5), .ir_11(ir_11), .ben(ben),
            .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_ben(ld_ben),
            .ld_cc(ld_cc), .ld_reg(ld_reg), .ld_pc(ld_pc), .ld_led(ld_led),
            .gate_pc(gate_pc), .gate_mdr(gate_mdr), .gate_alu(gate_alu),
            .gate_marmux(gate_marmux), .sr2mux(sr2mux), .addr1mux(addr1mux),
            .marmux(marmux), .drmux(drmux), .sr1mux(sr1mux), .mio_en(mio_en),
            .pcmux(pcmux), .addr2mux(addr2mux), .aluk(aluk),
            .mem_oe(mem_oe), .mem_we(mem_we)
        );

        assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                         gate_pc, gate_mdr, gate_alu, gate_marmux, sr2mux, addr1mux,
                         marmux, drmux, sr1mux, mio_en, pcmux, addr2mux, aluk,
                         mem_oe, mem_we};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.tag, 32'(obs[act]), 32'(e.exp));
        end
    end

    function automatic int mw_of(input int a);
        return (a == 0) ? 1 : ((a == 1) ? 3 : 15);
    endfunction

    task automatic push(input string tag, input vec_t v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic push_mem(input string tag, input int mw, input bit rd);
        for (int i = 0; i < mw; i++) begin
            if (rd) push(tag, MIO_EN | MEM_OE | ((i == mw - 1) ? LD_MDR : 26'h0));
            else    push(tag, MEM_WE);
        end
    endtask

    task automatic push_fetch(input string name, input int mw);
        push({name, ".S18"}, GATE_PC | LD_MAR | LD_PC);
        push_mem({name, ".S33"}, mw, 1'b1);
        push({name, ".S35"}, GATE_MDR | LD_IR);
        push({name, ".S32"}, LD_BEN);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() > 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb_q.size() > 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic reset_dut(input int g);
        rst_n_v = 3'b000;
        run = 1'b0;
        cont = 1'b0;
        act = g;
        repeat (2) begin @(posedge clk); #1; end
        rst_n_v[g] = 1'b1;
        push("reset", 26'h0);
        push("reset", 26'h0);
        drain();
    endtask

    task automatic start();
        run = 1'b1;
        push("halted", 26'h0);
        drain();
        run = 1'b0;
    endtask

    // Called on the first (S18) cycle of an instruction.
    task automatic run_instr(input string name, input logic [3:0] op,
                             input logic i5, input logic i11, input logic b);
        int mw;
        mw = mw_of(act);
        opcode = op; ir_5 = i5; ir_11 = i11; ben = b;
        push_fetch(name, mw);
        case (op)
            4'b0001: push({name, ".alu"}, GATE_ALU | LD_REG | LD_CC | SR1MUX | (i5 ? 26'h0 : SR2MUX));
            4'b0101: push({name, ".alu"}, GATE_ALU | LD_REG | LD_CC | SR1MUX | (i5 ? 26'h0 : SR2MUX) | K_AND);
            4'b1001: push({name, ".alu"}, GATE_ALU | LD_REG | LD_CC | SR1MUX | (i5 ? 26'h0 : SR2MUX) | K_NOT);
            4'b0000: begin
                push({name, ".S0"}, 26'h0);
                if (b) push({name, ".S22"}, A2_OFF9 | PC_ADDER | LD_PC);
            end
            4'b1100: push({name, ".S12"}, ADDR1MUX | SR1MUX | PC_ADDER | LD_PC);
            4'b0100: begin
                push({name, ".S4"}, GATE_PC | DRMUX | LD_REG);
                if (i11) push({name, ".S21"}, A2_OFF11 | PC_ADDER | LD_PC);
                else     push({name, ".S20"}, ADDR1MUX | SR1MUX | PC_ADDER | LD_PC);
            end
            4'b0110: begin
                push({name, ".S6"}, ADDR1MUX | A2_OFF6 | SR1MUX | GATE_MARMUX | LD_MAR);
                push_mem({name, ".S25"}, mw, 1'b1);
                push({name, ".S27"}, GATE_MDR | LD_REG | LD_CC);
            end
            4'b0111: begin
                push({name, ".S7"}, ADDR1MUX | A2_OFF6 | SR1MUX | GATE_MARMUX | LD_MAR);
                push({name, ".S23"}, GATE_ALU | K_PASS | LD_MDR);
                push_mem({name, ".S16"}, mw, 1'b0);
            end
`ifdef SLC3_PAUSE_EN
            4'b1101: begin
                repeat (3) push({name, ".P1"}, LD_LED);
                repeat (2) push({name, ".P2"}, 26'h0);
                repeat (mw + 5) begin @(posedge clk); #1; end
                cont = 1'b1;
                repeat (2) begin @(posedge clk); #1; end
                cont = 1'b0;
            end
`endif
            default: ;
        endcase
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // MEM_WAIT = 3: reset in the middle of a store write.
        reset_dut(1);
        start();
        opcode = 4'b0111; ir_5 = 1'b0; ir_11 = 1'b0; ben = 1'b0;
        push_fetch("rst", 3);
        push("rst.S7", ADDR1MUX | A2_OFF6 | SR1MUX | GATE_MARMUX | LD_MAR);
        push("rst.S23", GATE_ALU | K_PASS | LD_MDR);
        push("rst.S16", MEM_WE);
        drain();
        check("rst.we_before", 32'(obs[1][0]), 32'd1);
        #2 rst_n_v[1] = 1'b0;
        #1;
        check("rst.we_async", 32'(obs[1][0]), 32'd0);
        check("rst.all_zero", 32'(obs[1]), 32'd0);
        @(posedge clk); #1;
        rst_n_v[1] = 1'b1;
        repeat (4) push("rst.idle", 26'h0);
        drain();

        start();
        run_instr("add_imm", 4'b0001, 1'b1, 1'b0, 1'b0);
        run_instr("add_reg", 4'b0001, 1'b0, 1'b0, 1'b0);
        run_instr("and",     4'b0101, 1'b1, 1'b0, 1'b0);
        run_instr("not",     4'b1001, 1'b1, 1'b0, 1'b0);
        run_instr("br_nt",   4'b0000, 1'b0, 1'b0, 1'b0);
        run_instr("br_t",    4'b0000, 1'b0, 1'b0, 1'b1);
        run_instr("jmp",     4'b1100, 1'b0, 1'b0, 1'b0);
        run_instr("jsrr",    4'b0100, 1'b0, 1'b0, 1'b0);
        run_instr("jsr",     4'b0100, 1'b0, 1'b1, 1'b0);
        run_instr("ldr",     4'b0110, 1'b0, 1'b0, 1'b0);
        run_instr("str",     4'b0111, 1'b0, 1'b0, 1'b0);
        run_instr("pause",   4'b1101, 1'b0, 1'b0, 1'b0);
        run_instr("illegal", 4'b1000, 1'b0, 1'b0, 1'b0);
        run_instr("add_end", 4'b0001, 1'b0, 1'b0, 1'b0);

        // MEM_WAIT = 1
        reset_dut(0);
        start();
        run_instr("ldr_w1", 4'b0110, 1'b0, 1'b0, 1'b0);
        run_instr("str_w1", 4'b0111, 1'b0, 1'b0, 1'b0);
        run_instr("add_w1", 4'b0001, 1'b1, 1'b0, 1'b0);

        // MEM_WAIT = 15
        reset_dut(2);
        start();
        run_instr("ldr_w15", 4'b0110, 1'b0, 1'b0, 1'b0);
        run_instr("br_w15",  4'b0000, 1'b0, 1'b0, 1'b1);
        run_instr("add_w15", 4'b0001, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
